// File: rtl/mul_div_unit_pkg.sv
// Shared widths, funct codes and FSM state type for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned CNT_W   = 5;

    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    function automatic logic is_muldiv(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Shift-add multiply and restoring divide share one 64-bit working register.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [DATA_W-1:0]  operand_1,
    input  logic [DATA_W-1:0]  operand_2,
    output logic               stall_request,
    output logic               done,
    output logic [DATA_W-1:0]  hi,
    output logic [DATA_W-1:0]  lo
);

    md_state_t              state;
    md_state_t              state_next;
    logic [CNT_W-1:0]       count;
    logic                   op_div;
    logic                   neg_res;
    logic                   neg_rem;
    logic                   div_zero;
    logic [DATA_W-1:0]      a_reg;
    logic [DATA_W-1:0]      b_reg;
    logic [DATA_W-1:0]      hi_work;
    logic [DATA_W-1:0]      lo_work;

    logic                   accept;
    logic                   sgn_in;
    logic                   div_in;
    logic [DATA_W-1:0]      mag_1;
    logic [DATA_W-1:0]      mag_2;
    logic [DATA_W:0]        mul_sum;
    logic [DATA_W:0]        div_shift;
    logic [DATA_W+1:0]      div_diff;
    logic                   div_ge;
    logic [2*DATA_W-1:0]    product;

    // Next-state and stall decode
    always_comb begin
        state_next    = state;
        accept        = (state == ST_IDLE) && start && is_muldiv(funct) && !flush;
        unique case (state)
            ST_IDLE: if (accept) state_next = ST_CALC;
            ST_CALC: if (count == CNT_W'(31)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
        stall_request = accept || (state == ST_CALC) || (state == ST_FIX);
    end

    // Operand magnitudes and per-iteration datapath
    always_comb begin
        sgn_in    = !funct[0];
        div_in    = funct[1];
        mag_1     = (sgn_in && operand_1[DATA_W-1]) ? DATA_W'(-operand_1) : operand_1;
        mag_2     = (sgn_in && operand_2[DATA_W-1]) ? DATA_W'(-operand_2) : operand_2;
        mul_sum   = lo_work[0] ? ({1'b0, hi_work} + {1'b0, a_reg}) : {1'b0, hi_work};
        div_shift = {hi_work, lo_work[DATA_W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_reg};
        div_ge    = !div_diff[DATA_W+1];
        product   = {hi_work, lo_work};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            hi_work  <= '0;
            lo_work  <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (!flush) begin
                unique case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            op_div   <= div_in;
                            neg_res  <= sgn_in && (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
                            neg_rem  <= sgn_in && operand_1[DATA_W-1];
                            div_zero <= div_in && (operand_2 == '0);
                            a_reg    <= mag_1;
                            b_reg    <= mag_2;
                            count    <= '0;
                            hi_work  <= '0;
                            lo_work  <= div_in ? mag_1 : mag_2;
                        end
                    end
                    ST_CALC: begin
                        count <= CNT_W'(count + 1'b1);
                        if (op_div) begin
                            hi_work <= div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
                            lo_work <= {lo_work[DATA_W-2:0], div_ge};
                        end else begin
                            {hi_work, lo_work} <= {mul_sum, lo_work[DATA_W-1:1]};
                        end
                    end
                    ST_FIX: begin
                        done <= 1'b1;
                        if (!op_div) begin
                            {hi, lo} <= neg_res ? (2*DATA_W)'(-product) : product;
                        end else if (div_zero) begin
                            // neg_rem restores the original signed dividend from its magnitude
                            lo <= '1;
                            hi <= neg_rem ? DATA_W'(-a_reg) : a_reg;
                        end else begin
                            lo <= neg_res ? DATA_W'(-lo_work) : lo_work;
                            hi <= neg_rem ? DATA_W'(-hi_work) : hi_work;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: table of operations plus abort and ignored-start sequences.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              start;
    logic [5:0]        funct;
    logic [31:0]       operand_1;
    logic [31:0]       operand_2;
    logic              stall_request;
    logic              done;
    logic [31:0]       hi;
    logic [31:0]       lo;

    int checks   = 0;
    int failures = 0;

    mul_div_unit dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .start         (start),
        .funct         (funct),
        .operand_1     (operand_1),
        .operand_2     (operand_2),
        .stall_request (stall_request),
        .done          (done),
        .hi            (hi),
        .lo            (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        bit          poke;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one op at the next negedge and follow it until done (bounded).
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, output int lat, output int stalls);
        @(negedge clk);
        start = 1'b1; funct = f; operand_1 = a; operand_2 = b;
        lat = 0; stalls = 0;
        #1;
        while (!done && lat < 60) begin
            if (stall_request) stalls++;
            @(negedge clk);
            lat++;
            start     = poke && (lat == 5);
            operand_1 = ~a;
            operand_2 = b + 32'd1;
            #1;
        end
        start = 1'b0;
    endtask

    task automatic abort_seq(input bit use_rst, input string tag);
        logic [31:0] pre_hi, pre_lo;
        bit seen;
        pre_hi = hi; pre_lo = lo;
        @(negedge clk);
        start = 1'b1; funct = FUNCT_DIV; operand_1 = 32'd100; operand_2 = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        #1;
        check({tag, "_stall_t11"}, 64'(stall_request), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            if (done || stall_request) seen = 1'b1;
            @(negedge clk);
            #1;
        end
        check({tag, "_no_done"}, 64'(seen), 64'd0);
        check({tag, "_hi"}, 64'(hi), use_rst ? 64'd0 : 64'(pre_hi));
        check({tag, "_lo"}, 64'(lo), use_rst ? 64'd0 : 64'(pre_lo));
    endtask

    initial begin
        int lat, stalls;
        bit seen;

        vecs[0]  = '{FUNCT_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[1]  = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{FUNCT_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{FUNCT_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b1};
        vecs[5]  = '{FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{FUNCT_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{FUNCT_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{FUNCT_MULT,  32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000002, 1'b1};
        vecs[9]  = '{FUNCT_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[10] = '{FUNCT_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[11] = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[12] = '{FUNCT_DIVU,  32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h00000001, 1'b0};
        vecs[13] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};

        rst = 1'b1; flush = 1'b0; start = 1'b0; funct = '0; operand_1 = '0; operand_2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_stall", 64'(stall_request), 64'd0);

        // Back-to-back: each op issued the cycle after the previous done
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].poke, lat, stalls);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd34);
            check($sformatf("v%0d_stall_cycles", i), 64'(stalls), 64'd34);
            check($sformatf("v%0d_stall_at_done", i), 64'(stall_request), 64'd0);
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
        end
        @(negedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);

        // Non-muldiv funct (ADDU) is ignored
        start = 1'b1; funct = 6'h21; operand_1 = 32'd9; operand_2 = 32'd9;
        #1;
        check("addu_stall", 64'(stall_request), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done || stall_request) seen = 1'b1;
        end
        check("addu_no_activity", 64'(seen), 64'd0);
        check("addu_hi_hold", 64'(hi), 64'hFFFFFFFF);
        check("addu_lo_hold", 64'(lo), 64'h00000003);

        // Flush coinciding with an accepting start
        @(negedge clk);
        start = 1'b1; funct = FUNCT_MULT; operand_1 = 32'd3; operand_2 = 32'd3; flush = 1'b1;
        #1;
        check("flush_accept_stall", 64'(stall_request), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            #1;
            if (done || stall_request) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_accept_no_op", 64'(seen), 64'd0);
        check("flush_accept_lo_hold", 64'(lo), 64'h00000003);

        abort_seq(1'b0, "flush_t10");
        abort_seq(1'b1, "rst_t10");

        // Recovery after mid-operation reset
        run_op(FUNCT_MULTU, 32'd3, 32'd4, 1'b0, lat, stalls);
        check("recover_latency", 64'(lat), 64'd34);
        check("recover_lo", 64'(lo), 64'd12);
        check("recover_hi", 64'(hi), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
